// File: rtl/cic_decimator.sv
// Third-order CIC decimator (M=1, R=2^DEC_LOG2) turning a 1-bit delta-sigma stream into signed PCM.
// Integrators run at the clk_en bit rate; the comb pipeline and output stage run on every clk edge.
module cic_decimator #(
  parameter int DATA_WIDTH = 16,
  parameter int DEC_LOG2   = 6
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clk_en,
  input  logic                         dsm_in,
  output logic signed [DATA_WIDTH-1:0] dout,
  output logic                         dout_valid
);

  localparam int ACC_W     = 3*DEC_LOG2 + 2;
  localparam int SHIFT_RAW = ACC_W - 1 - DATA_WIDTH;
  localparam int SHIFT     = (SHIFT_RAW < 0) ? 0 : SHIFT_RAW;

  localparam logic signed [ACC_W-1:0] SAT_HI = {2'b00, {(ACC_W-2){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_LO = {2'b11, {(ACC_W-2){1'b0}}};
  localparam logic [DEC_LOG2-1:0]     CNT_MAX = '1;

  logic [ACC_W-1:0]    i1_q, i1_d, i2_q, i2_d, i3_q, i3_d;
  logic [DEC_LOG2-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0]    dec_q, dec_d;
  logic                v0_q, v0_d;
  logic [ACC_W-1:0]    c1_q, c1_d, d1_q, d1_d;
  logic [ACC_W-1:0]    c2_q, c2_d, d2_q, d2_d;
  logic [ACC_W-1:0]    c3_q, c3_d, d3_q, d3_d;
  logic                v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic signed [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                dout_valid_q, dout_valid_d;

  logic [ACC_W-1:0]        x;
  logic                    capture;
  logic signed [ACC_W-1:0] c3_s, sat, shifted;

  // +1 for a one, -1 (all ones) for a zero
  assign x       = {{(ACC_W-1){~dsm_in}}, 1'b1};
  assign capture = clk_en && (cnt_q == CNT_MAX);

  always_comb begin
    i1_d  = i1_q;
    i2_d  = i2_q;
    i3_d  = i3_q;
    cnt_d = cnt_q;
    if (clk_en) begin
      i1_d  = i1_q + x;
      i2_d  = i2_q + i1_q;
      i3_d  = i3_q + i2_q;
      cnt_d = cnt_q + 1'b1;
    end
    dec_d = capture ? i3_q : dec_q;
    v0_d  = capture;
  end

  // Each comb stage and its delay register move only when a token passes.
  always_comb begin
    c1_d = c1_q;
    d1_d = d1_q;
    v1_d = 1'b0;
    c2_d = c2_q;
    d2_d = d2_q;
    v2_d = 1'b0;
    c3_d = c3_q;
    d3_d = d3_q;
    v3_d = 1'b0;
    if (v0_q) begin
      c1_d = dec_q - d1_q;
      d1_d = dec_q;
      v1_d = 1'b1;
    end
    if (v1_q) begin
      c2_d = c1_q - d2_q;
      d2_d = c1_q;
      v2_d = 1'b1;
    end
    if (v2_q) begin
      c3_d = c2_q - d3_q;
      d3_d = c2_q;
      v3_d = 1'b1;
    end
  end

  always_comb begin
    c3_s = $signed(c3_q);
    sat  = c3_s;
    if (c3_s > SAT_HI) sat = SAT_HI;
    if (c3_s < SAT_LO) sat = SAT_LO;
    shifted      = sat >>> SHIFT;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    if (v3_q) begin
      dout_d       = DATA_WIDTH'(shifted);
      dout_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i1_q         <= '0;
      i2_q         <= '0;
      i3_q         <= '0;
      cnt_q        <= '0;
      dec_q        <= '0;
      v0_q         <= 1'b0;
      c1_q         <= '0;
      d1_q         <= '0;
      v1_q         <= 1'b0;
      c2_q         <= '0;
      d2_q         <= '0;
      v2_q         <= 1'b0;
      c3_q         <= '0;
      d3_q         <= '0;
      v3_q         <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      i1_q         <= i1_d;
      i2_q         <= i2_d;
      i3_q         <= i3_d;
      cnt_q        <= cnt_d;
      dec_q        <= dec_d;
      v0_q         <= v0_d;
      c1_q         <= c1_d;
      d1_q         <= d1_d;
      v1_q         <= v1_d;
      c2_q         <= c2_d;
      d2_q         <= d2_d;
      v2_q         <= v2_d;
      c3_q         <= c3_d;
      d3_q         <= d3_d;
      v3_q         <= v3_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;

endmodule

// File: tb/tb_cic_decimator.sv
// Scoreboard bench for cic_decimator: stimulus pushes expected strobe time/value, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_cic_decimator;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clk_en = 1'b0;
  logic dsm_in = 1'b0;
  logic signed [15:0] dout;
  logic dout_valid;

  cic_decimator #(.DATA_WIDTH(16), .DEC_LOG2(6)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .dsm_in(dsm_in),
    .dout(dout), .dout_valid(dout_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                 cyc;
    bit                 chk;
    logic signed [15:0] val;
  } exp_t;

  exp_t sb[$];
  int cyc = 0;
  int base = 0;
  int npulse = 0;
  int errors = 0;
  int checks = 0;
  logic signed [15:0] prev_dout = '0;
  logic prev_rst = 1'b0;

  always @(posedge clk) cyc++;

  // Monitor: every strobe must match the head of the scoreboard; between strobes dout must hold.
  always @(negedge clk) begin
    exp_t e;
    if (dout_valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe at cycle %0d dout=%0d", cyc, dout);
      end else begin
        e = sb.pop_front();
        if (cyc != e.cyc) begin
          errors++;
          $display("FAIL strobe_time got=%0d exp=%0d", cyc, e.cyc);
        end
        if (e.chk) begin
          checks++;
          if (dout !== e.val) begin
            errors++;
            $display("FAIL strobe_value cycle=%0d got=%0d exp=%0d", cyc, dout, e.val);
          end
        end
      end
    end else if (rst && prev_rst) begin
      checks++;
      if (dout !== prev_dout) begin
        errors++;
        $display("FAIL dout_hold cycle=%0d got=%0d exp=%0d", cyc, dout, prev_dout);
      end
    end
    prev_dout = dout;
    prev_rst  = rst;
  end

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // Called at posedge+2; asserts reset, checks the async clear, releases three cycles later.
  task automatic do_reset();
    rst = 1'b0;
    clk_en = 1'b0;
    #1;
    check("reset_dout", int'(dout), 0);
    check("reset_valid", int'(dout_valid), 0);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    base = cyc;
    npulse = 0;
  endtask

  // mode: 0 = constant zeros, 1 = constant ones, 2 = alternating 1,0,1,0
  task automatic run_cycles(input int mode, input int div, input int n);
    int e;
    bit en;
    while (cyc - base < n) begin
      e  = cyc + 1 - base;
      en = (div == 1) || (e % div == 0);
      clk_en = en;
      if (en) begin
        dsm_in = (mode == 2) ? ((npulse % 2) == 0) : (mode == 1);
        npulse++;
      end
      @(posedge clk);
      #2;
    end
  endtask

  task automatic push_run(input int mode, input int div, input int n);
    exp_t e;
    for (int j = 1; j <= n; j++) begin
      e.cyc = base + 64*div + 4 + 64*div*(j-1);
      e.chk = (j >= 4);
      e.val = (mode == 1) ? 16'sd32767 : (mode == 0) ? -16'sd32768 : 16'sd0;
      sb.push_back(e);
    end
  endtask

  task automatic drain_check(input string name);
    check(name, sb.size(), 0);
    sb.delete();
  endtask

  task automatic phase(input int mode, input int div, input int n, input string name);
    do_reset();
    push_run(mode, div, n);
    run_cycles(mode, div, 64*div*n + 6);
    drain_check(name);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2;
    phase(1, 1, 6, "drain_ones");
    phase(0, 1, 6, "drain_zeros");
    phase(2, 1, 6, "drain_alt");

    // Reset two cycles after a capture edge: that token must never emerge.
    do_reset();
    push_run(1, 1, 3);
    run_cycles(1, 1, 64*4 + 2);
    drain_check("drain_pre_reset");
    do_reset();
    push_run(1, 1, 4);
    run_cycles(1, 1, 67);
    check("post_reset_dout", int'(dout), 0);
    check("post_reset_valid", int'(dout_valid), 0);
    run_cycles(1, 1, 64*4 + 6);
    drain_check("drain_post_reset");

    phase(1, 100, 5, "drain_div100");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
